// File: rtl/pps_pkg.sv
// Shared definitions for the PPS-synchronised trigger train.
// Contents:
//   state_t          FSM encoding of the receive-side monitor (IDLE/ARMED/HIGH)
//   DEF_PULSE_NUM    default trigger pulses per SYNC window (also used by the generator)
//   DEF_HALF_PERIOD  default trigger high time in clock cycles (also used by the generator)
//   sat_inc()        32-bit increment that sticks at all-ones instead of wrapping
package pps_pkg;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      ARMED = 4'd1,
      HIGH  = 4'd2
   } state_t;

   localparam int unsigned DEF_PULSE_NUM   = 100;
   localparam int unsigned DEF_HALF_PERIOD = 500000;

   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// Brings one asynchronous pin into the clock domain and produces edge strobes.
// A 2-FF synchroniser is followed by one delay register; the rise/fall strobes
// are registered, so a pin edge shows up as a strobe three clocks later.
// Ports:
//   i_clk   in  1  system clock
//   i_rst   in  1  synchronous, active-high reset
//   i_pin   in  1  asynchronous input
//   o_rise  out 1  1-cycle strobe on a synchronised rising edge
//   o_fall  out 1  1-cycle strobe on a synchronised falling edge
module pps_edge_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_pin,
   output logic o_rise,
   output logic o_fall
);

   logic meta;
   logic cur;
   logic prev;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         meta   <= 1'b0;
         cur    <= 1'b0;
         prev   <= 1'b0;
         o_rise <= 1'b0;
         o_fall <= 1'b0;
      end else begin
         meta   <= i_pin;
         cur    <= meta;
         prev   <= cur;
         o_rise <= cur & ~prev;
         o_fall <= ~cur & prev;
      end
   end

endmodule

// File: rtl/pps_trig_monitor.sv
// Receive-side checker for the PPS-synchronised trigger train. Between
// consecutive SYNC rising edges it counts trigger pulses, measures the high
// width and rise-to-rise period of each pulse, and reports count and width
// errors when the window closes. A window left open for SYNC_TIMEOUT cycles is
// force-closed and flagged as lost SYNC.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_sync, i_trig  asynchronous SYNC and trigger pins
//   o_pulse_count   pulses counted in the last closed window
//   o_high_width    high width of the last completed pulse (cycles)
//   o_period        rise-to-rise distance of the last two pulses in a window
//   o_window_done   1-cycle strobe when a window closes and status updates
//   o_err_missing   last window had fewer than PULSE_NUM pulses
//   o_err_extra     last window had more than PULSE_NUM pulses
//   o_err_width     last window had a width outside HALF_PERIOD +/- WIDTH_TOL
//   o_sync_lost     timeout fired; cleared by the next SYNC rising edge
//   o_cstate        FSM state for debug
module pps_trig_monitor
   import pps_pkg::*;
#(
   parameter int unsigned PULSE_NUM    = DEF_PULSE_NUM,
   parameter int unsigned HALF_PERIOD  = DEF_HALF_PERIOD,
   parameter int unsigned WIDTH_TOL    = 16,
   parameter int unsigned SYNC_TIMEOUT = 110000000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_sync,
   input  logic        i_trig,
   output logic [31:0] o_pulse_count,
   output logic [31:0] o_high_width,
   output logic [31:0] o_period,
   output logic        o_window_done,
   output logic        o_err_missing,
   output logic        o_err_extra,
   output logic        o_err_width,
   output logic        o_sync_lost,
   output logic [3:0]  o_cstate
);

   localparam logic [31:0] PULSE_NUM_W    = 32'(PULSE_NUM);
   localparam logic [31:0] HALF_PERIOD_W  = 32'(HALF_PERIOD);
   localparam logic [32:0] WIDTH_TOL_W    = 33'(WIDTH_TOL);
   localparam logic [31:0] TIMEOUT_LAST   = 32'(SYNC_TIMEOUT - 1);

   logic sync_rise;
   logic sync_fall;
   logic trig_rise;
   logic trig_fall;

   pps_edge_sync u_sync (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_pin  (i_sync),
      .o_rise (sync_rise),
      .o_fall (sync_fall)
   );

   pps_edge_sync u_trig (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_pin  (i_trig),
      .o_rise (trig_rise),
      .o_fall (trig_fall)
   );

   state_t      state;
   logic [31:0] cnt;
   logic [31:0] wtimer;
   logic [31:0] width_cnt;
   logic [31:0] period_cnt;
   logic        have_rise;
   logic        werr;

   // SYNC falling edges carry no meaning for the monitor.
   logic unused_ok;
   assign unused_ok = sync_fall;

   // Signed 33-bit difference so widths shorter than HALF_PERIOD are caught too.
   logic signed [32:0] width_diff;
   logic        [32:0] width_mag;
   logic               width_bad;
   assign width_diff = $signed({1'b0, width_cnt}) - $signed({1'b0, HALF_PERIOD_W});
   assign width_mag  = width_diff[32] ? 33'(-width_diff) : 33'(width_diff);
   assign width_bad  = width_mag > WIDTH_TOL_W;

   // A SYNC edge takes priority over a timeout landing in the same cycle.
   logic in_window;
   logic timeout;
   logic close_win;
   assign in_window = (state == ARMED) || (state == HIGH);
   assign timeout   = in_window && !sync_rise && (wtimer == TIMEOUT_LAST);
   assign close_win = in_window && (sync_rise || timeout);

   assign o_cstate = state;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= IDLE;
         cnt           <= '0;
         wtimer        <= '0;
         width_cnt     <= '0;
         period_cnt    <= '0;
         have_rise     <= 1'b0;
         werr          <= 1'b0;
         o_pulse_count <= '0;
         o_high_width  <= '0;
         o_period      <= '0;
         o_window_done <= 1'b0;
         o_err_missing <= 1'b0;
         o_err_extra   <= 1'b0;
         o_err_width   <= 1'b0;
         o_sync_lost   <= 1'b0;
      end else begin
         o_window_done <= 1'b0;

         if (close_win) begin
            o_window_done <= 1'b1;
            o_pulse_count <= cnt;
            o_err_missing <= cnt < PULSE_NUM_W;
            o_err_extra   <= cnt > PULSE_NUM_W;
            o_err_width   <= werr;
         end

         case (state)
            IDLE: begin
               if (sync_rise) begin
                  state       <= ARMED;
                  cnt         <= '0;
                  wtimer      <= '0;
                  period_cnt  <= '0;
                  have_rise   <= 1'b0;
                  werr        <= 1'b0;
                  o_sync_lost <= 1'b0;
               end
            end

            ARMED, HIGH: begin
               wtimer     <= sat_inc(wtimer);
               period_cnt <= sat_inc(period_cnt);
               if (sync_rise) begin
                  // New window opens immediately; a pulse in progress stays
                  // with the old window and its width is never judged.
                  wtimer <= '0;
                  werr   <= 1'b0;
                  if (state == ARMED && trig_rise) begin
                     // Coincident trigger belongs to the new window.
                     state      <= HIGH;
                     cnt        <= 32'd1;
                     width_cnt  <= 32'd1;
                     period_cnt <= 32'd1;
                     have_rise  <= 1'b1;
                  end else begin
                     state     <= ARMED;
                     cnt       <= '0;
                     have_rise <= 1'b0;
                  end
               end else if (timeout) begin
                  state       <= IDLE;
                  o_sync_lost <= 1'b1;
               end else if (state == ARMED) begin
                  if (trig_rise) begin
                     state      <= HIGH;
                     cnt        <= sat_inc(cnt);
                     width_cnt  <= 32'd1;
                     period_cnt <= 32'd1;
                     have_rise  <= 1'b1;
                     if (have_rise) o_period <= period_cnt;
                  end
               end else begin
                  if (trig_fall) begin
                     state        <= ARMED;
                     o_high_width <= width_cnt;
                     if (width_bad) werr <= 1'b1;
                  end else begin
                     width_cnt <= sat_inc(width_cnt);
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
